// File: rtl/cpc_vram_scheduler.sv
// Shares the 64 KB video/system RAM between the CRTC display fetch and the Z80.
// Each microsecond is 16 phases: video bytes in slots 1 and 5, CPU access in slot 9.
module cpc_vram_scheduler (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_clken,
    input  logic        i_video_en,
    input  logic [13:0] i_ma,
    input  logic [4:0]  i_ra,
    output logic        o_crtc_clken,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [15:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_di,
    output logic [7:0]  o_cpu_do,
    output logic        o_cpu_ack,
    output logic        o_cpu_wait,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic [7:0]  o_mem_do,
    input  logic [7:0]  i_mem_di,
    output logic [15:0] o_vid_data,
    output logic        o_vid_valid
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t      r_state;
    logic [3:0]  r_ph;
    logic        r_vid_act;
    logic [14:0] r_vid_base;
    logic [7:0]  r_byte0;
    logic [15:0] r_mem_addr;
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic [7:0]  r_mem_do;
    logic        r_cpu_we;
    logic [7:0]  r_cpu_do;
    logic        r_cpu_ack;
    logic [15:0] r_vid_data;
    logic        r_vid_valid;

    logic        w_cpu_start;
    logic [14:0] w_vid_base;
    logic        w_unused;

    // MA[11:10] and RA[4:3] do not take part in the character address.
    assign w_unused    = ^{i_ma[11:10], i_ra[4:3]};
    assign w_vid_base  = {i_ma[13:12], i_ra[2:0], i_ma[9:0]};
    assign w_cpu_start = i_cpu_req && (r_ph == 4'd8) &&
                         (r_state == ST_IDLE || r_state == ST_PEND);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_ph        <= 4'd0;
            r_vid_act   <= 1'b0;
            r_vid_base  <= '0;
            r_byte0     <= '0;
            r_mem_addr  <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_do    <= '0;
            r_cpu_we    <= 1'b0;
            r_cpu_do    <= '0;
            r_cpu_ack   <= 1'b0;
            r_vid_data  <= '0;
            r_vid_valid <= 1'b0;
        end else begin
            // NOTE: pulses clear on every CLOCK, so they last one CLOCK even when CLKEN stalls.
            r_cpu_ack   <= 1'b0;
            r_vid_valid <= 1'b0;
            if (i_clken) begin
                r_ph     <= r_ph + 4'd1;
                r_mem_rd <= 1'b0;
                r_mem_wr <= 1'b0;

                case (r_ph)
                    4'd0: begin
                        r_vid_act  <= i_video_en;
                        r_vid_base <= w_vid_base;
                        if (i_video_en) begin
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= {w_vid_base, 1'b0};
                        end
                    end
                    4'd2: if (r_vid_act) r_byte0 <= i_mem_di;
                    4'd4: if (r_vid_act) begin
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= {r_vid_base, 1'b1};
                    end
                    4'd6: if (r_vid_act) begin
                        r_vid_data  <= {i_mem_di, r_byte0};
                        r_vid_valid <= 1'b1;
                    end
                    default: ;
                endcase

                // CPU slot strobes are set at the edge ending slot 8.
                if (w_cpu_start) begin
                    r_state    <= ST_ACCESS;
                    r_mem_addr <= i_cpu_addr;
                    r_mem_wr   <= i_cpu_we;
                    r_mem_rd   <= ~i_cpu_we;
                    r_mem_do   <= i_cpu_di;
                    r_cpu_we   <= i_cpu_we;
                end else begin
                    case (r_state)
                        ST_IDLE:   if (i_cpu_req) r_state <= ST_PEND;
                        ST_PEND:   if (!i_cpu_req) r_state <= ST_IDLE;
                        ST_ACCESS: r_state <= ST_DONE;
                        ST_DONE: begin
                            if (!r_cpu_we) r_cpu_do <= i_mem_di;
                            r_cpu_ack <= 1'b1;
                            r_state   <= ST_IDLE;
                        end
                        default:   r_state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign o_crtc_clken = i_clken && (r_ph == 4'd15);
    assign o_cpu_wait   = i_cpu_req && !r_cpu_ack;
    assign o_cpu_do     = r_cpu_do;
    assign o_cpu_ack    = r_cpu_ack;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_rd     = r_mem_rd;
    assign o_mem_wr     = r_mem_wr;
    assign o_mem_do     = r_mem_do;
    assign o_vid_data   = r_vid_data;
    assign o_vid_valid  = r_vid_valid;

endmodule

// File: tb/tb_cpc_vram_scheduler.sv
// Directed bench for cpc_vram_scheduler: a per-slot vector table for one
// microsecond plus hand-written sequences for latency, reset and CLKEN stalls.
module tb_cpc_vram_scheduler;

    logic        clk;
    logic        i_reset;
    logic        i_clken;
    logic        i_video_en;
    logic [13:0] i_ma;
    logic [4:0]  i_ra;
    logic        o_crtc_clken;
    logic        i_cpu_req;
    logic        i_cpu_we;
    logic [15:0] i_cpu_addr;
    logic [7:0]  i_cpu_di;
    logic [7:0]  o_cpu_do;
    logic        o_cpu_ack;
    logic        o_cpu_wait;
    logic [15:0] o_mem_addr;
    logic        o_mem_rd;
    logic        o_mem_wr;
    logic [7:0]  o_mem_do;
    logic [7:0]  i_mem_di;
    logic [15:0] o_vid_data;
    logic        o_vid_valid;

    int checks = 0;
    int errors = 0;

    cpc_vram_scheduler dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_clken      (i_clken),
        .i_video_en   (i_video_en),
        .i_ma         (i_ma),
        .i_ra         (i_ra),
        .o_crtc_clken (o_crtc_clken),
        .i_cpu_req    (i_cpu_req),
        .i_cpu_we     (i_cpu_we),
        .i_cpu_addr   (i_cpu_addr),
        .i_cpu_di     (i_cpu_di),
        .o_cpu_do     (o_cpu_do),
        .o_cpu_ack    (o_cpu_ack),
        .o_cpu_wait   (o_cpu_wait),
        .o_mem_addr   (o_mem_addr),
        .o_mem_rd     (o_mem_rd),
        .o_mem_wr     (o_mem_wr),
        .o_mem_do     (o_mem_do),
        .i_mem_di     (i_mem_di),
        .o_vid_data   (o_vid_data),
        .o_vid_valid  (o_vid_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: read data presented during the slot after the read strobe.
    logic [7:0] ram [0:65535];
    logic [7:0] rd_q;
    logic [3:0] tb_ph;

    always @(posedge clk) begin
        if (i_reset) begin
            tb_ph <= 4'd0;
            ram[16'hD000] <= 8'h12;
            ram[16'hD001] <= 8'h34;
            ram[16'hC000] <= 8'h9C;
            ram[16'hC001] <= 8'hE7;
            ram[16'h4000] <= 8'hA5;
        end else if (i_clken) begin
            tb_ph <= tb_ph + 4'd1;
            if (o_mem_rd) rd_q <= ram[o_mem_addr];
            if (o_mem_wr) ram[o_mem_addr] <= o_mem_do;
        end
    end
    assign i_mem_di = rd_q;

    typedef struct {
        logic        req;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic        ack;
        logic        vv;
        logic        wt;
    } vec_t;

    vec_t vt [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic goto_slot(input logic [3:0] target);
        for (int k = 0; k < 40 && tb_ph != target; k++) step();
        check("goto_slot", {28'd0, tb_ph}, {28'd0, target});
    endtask

    task automatic set_vec(input int i, input logic req, input logic rd,
                           input logic [15:0] addr, input logic ack,
                           input logic vv, input logic wt);
        vt[i] = '{req: req, rd: rd, wr: 1'b0, addr: addr, ack: ack, vv: vv, wt: wt};
    endtask

    int pulses, first_pulse, wr_cnt, wr_at, ack_at, acks, rd9, bad, vvs, wait_err;

    initial begin
        i_reset = 1'b1; i_clken = 1'b1; i_video_en = 1'b0;
        i_ma = '0; i_ra = '0; i_cpu_req = 1'b0; i_cpu_we = 1'b0;
        i_cpu_addr = '0; i_cpu_di = '0;

        // Per-slot expectations for one microsecond: video at MA=0x3000/RA=2
        // (address 0xD000/0xD001) and a CPU read of 0x4000 requested in slot 3.
        set_vec(0,  0, 0, 16'h0000, 0, 0, 0);
        set_vec(1,  0, 1, 16'hD000, 0, 0, 0);
        set_vec(2,  0, 0, 16'hD000, 0, 0, 0);
        set_vec(3,  1, 0, 16'hD000, 0, 0, 1);
        set_vec(4,  1, 0, 16'hD000, 0, 0, 1);
        set_vec(5,  1, 1, 16'hD001, 0, 0, 1);
        set_vec(6,  1, 0, 16'hD001, 0, 0, 1);
        set_vec(7,  1, 0, 16'hD001, 0, 1, 1);
        set_vec(8,  1, 0, 16'hD001, 0, 0, 1);
        set_vec(9,  1, 1, 16'h4000, 0, 0, 1);
        set_vec(10, 1, 0, 16'h4000, 0, 0, 1);
        set_vec(11, 1, 0, 16'h4000, 1, 0, 0);
        set_vec(12, 0, 0, 16'h4000, 0, 0, 0);
        set_vec(13, 0, 0, 16'h4000, 0, 0, 0);
        set_vec(14, 0, 0, 16'h4000, 0, 0, 0);
        set_vec(15, 0, 0, 16'h4000, 0, 0, 0);

        repeat (2) step();
        i_reset = 1'b0;

        // Reset state and CRTC clock enable on the 16th tick only.
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("crtc_clken_t%0d", i), {31'd0, o_crtc_clken}, {31'd0, i == 15});
            if (o_crtc_clken) pulses++;
            if (i < 15)
                check($sformatf("reset_outs_t%0d", i),
                      {o_mem_rd, o_mem_wr, o_cpu_ack, o_vid_valid, o_mem_addr, o_mem_do},
                      32'd0);
            step();
        end
        check("crtc_pulses", pulses, 1);
        check("reset_data", {o_vid_data, o_cpu_do, 8'd0}, 32'd0);

        // Table-driven microsecond: video fetch plus a CPU read.
        i_video_en = 1'b1; i_ma = 14'h3000; i_ra = 5'd2;
        i_cpu_addr = 16'h4000; i_cpu_we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            i_cpu_req = vt[i].req;
            #1;
            check($sformatf("slot%0d", i),
                  {o_mem_rd, o_mem_wr, o_cpu_ack, o_vid_valid, o_cpu_wait, o_mem_addr},
                  {vt[i].rd, vt[i].wr, vt[i].ack, vt[i].vv, vt[i].wt, vt[i].addr});
            step();
        end
        check("vid_data", {16'd0, o_vid_data}, 32'h3412);
        check("cpu_do_read", {24'd0, o_cpu_do}, 32'hA5);

        // Write requested in slot 9 misses this microsecond: 18-slot latency.
        i_video_en = 1'b0;
        goto_slot(4'd9);
        i_cpu_addr = 16'h8001; i_cpu_we = 1'b1; i_cpu_di = 8'h5A; i_cpu_req = 1'b1;
        wr_cnt = 0; wr_at = -1; ack_at = -1; wait_err = 0; vvs = 0;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (o_mem_wr) begin
                wr_cnt++; wr_at = n;
                check("wr_addr_data", {8'd0, o_mem_addr, o_mem_do}, {8'd0, 16'h8001, 8'h5A});
            end
            if (o_vid_valid) vvs++;
            if (o_cpu_wait !== !o_cpu_ack) wait_err++;
            if (o_cpu_ack) begin
                ack_at = n;
                break;
            end
            step();
        end
        check("wr_latency_ack", ack_at, 18);
        check("wr_slot", wr_at, 16);
        check("wr_count", wr_cnt, 1);
        check("wr_wait", wait_err, 0);
        check("wr_no_video", vvs, 0);
        step();
        i_cpu_req = 1'b0;
        check("ram_written", {24'd0, ram[16'h8001]}, 32'h5A);

        // Video off, REQ held for 32 ticks: two reads, slot-9 strobes only.
        i_cpu_we = 1'b0; i_cpu_req = 1'b1;
        acks = 0; rd9 = 0; bad = 0; vvs = 0;
        for (int n = 0; n < 32; n++) begin
            #1;
            if (o_cpu_ack) acks++;
            if (o_mem_rd && tb_ph == 4'd9) rd9++;
            if ((o_mem_rd && tb_ph != 4'd9) || o_mem_wr) bad++;
            if (o_vid_valid) vvs++;
            step();
        end
        i_cpu_req = 1'b0;
        check("b2b_acks", acks, 2);
        check("b2b_rd_slot9", rd9, 2);
        check("b2b_bad_strobes", bad, 0);
        check("b2b_no_vvalid", vvs, 0);
        check("b2b_cpu_do", {24'd0, o_cpu_do}, 32'h5A);
        check("b2b_vid_hold", {16'd0, o_vid_data}, 32'h3412);

        // Reset during the slot-9 write strobe.
        i_cpu_addr = 16'h1234; i_cpu_we = 1'b1; i_cpu_di = 8'h77; i_cpu_req = 1'b1;
        goto_slot(4'd9);
        check("rst_wr_before", {31'd0, o_mem_wr}, 32'd1);
        i_reset = 1'b1; i_cpu_req = 1'b0;
        step();
        check("rst_wr_dropped", {o_mem_wr, o_mem_rd, o_cpu_ack, o_mem_addr}, 19'd0);
        i_reset = 1'b0;
        acks = 0; first_pulse = -1;
        for (int n = 0; n < 20; n++) begin
            if (o_cpu_ack) acks++;
            if (o_crtc_clken && first_pulse < 0) first_pulse = n;
            step();
        end
        check("rst_no_ack", acks, 0);
        check("rst_ph_zero", first_pulse, 15);

        // CLKEN stall: VID_VALID stays one CLOCK; CRTC_CLKEN needs CLKEN.
        goto_slot(4'd0);
        i_video_en = 1'b1; i_ra = 5'd0;
        goto_slot(4'd7);
        check("stall_vv_first", {15'd0, o_vid_valid, o_vid_data}, {15'd0, 1'b1, 16'hE79C});
        i_clken = 1'b0;
        step();
        check("stall_vv_dropped", {31'd0, o_vid_valid}, 32'd0);
        repeat (3) step();
        i_clken = 1'b1;
        check("stall_ph_held", {28'd0, tb_ph}, 32'd7);
        goto_slot(4'd15);
        i_clken = 1'b0;
        #1;
        check("crtc_needs_clken", {31'd0, o_crtc_clken}, 32'd0);
        i_clken = 1'b1;
        #1;
        check("crtc_at_ph15", {31'd0, o_crtc_clken}, 32'd1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
